// File: rtl/wb_arbiter_pkg.sv
// Shared writeback-arbiter types: requester indices, the per-requester result
// record and the index width used for grant_id and the arbitration pointer.
package wb_arbiter_pkg;

  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;
  localparam int REQ_FPU = 2;

  // grant_id is architecturally 2 bits, so NREQ is limited to 4
  localparam int IDX_W = 2;

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] data;
    logic        is_freg;
  } wb_req_t;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx, input int n);
    logic [IDX_W-1:0] last;
    last = IDX_W'(n - 1);
    return (idx == last) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus between the result producers (master side) and the arbiter
// plus register-file write port (slave side).
interface wb_arbiter_if #(parameter int NREQ = 3);

  logic                  flush;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0][4:0]  req_dest;
  logic [NREQ-1:0][31:0] req_data;
  logic [NREQ-1:0]       req_is_freg;

  logic                  reg_w_enable;
  logic                  freg_w_enable;
  logic [4:0]            reg_w_dest;
  logic [31:0]           reg_w_data;
  logic [1:0]            grant_id;
  logic                  busy;

  modport master (
    output flush, req_valid, req_dest, req_data, req_is_freg,
    input  req_ready, reg_w_enable, freg_w_enable, reg_w_dest, reg_w_data,
           grant_id, busy
  );

  modport slave (
    input  flush, req_valid, req_dest, req_data, req_is_freg,
    output req_ready, reg_w_enable, freg_w_enable, reg_w_dest, reg_w_data,
           grant_id, busy
  );

endinterface

// File: rtl/wb_arbiter_rr_picker.sv
// One-hot requester pick: rotate by pointer, lowest-index priority encode, unrotate.
// With WB_ARBITER_RR_EN undefined the rotation is bypassed (fixed priority, no ptr port).
module rr_picker
  import wb_arbiter_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]     req,
`ifdef WB_ARBITER_RR_EN
  input  logic [IDX_W-1:0] ptr,
`endif
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [N-1:0]     rot;
  logic [IDX_W-1:0] enc;

`ifdef WB_ARBITER_RR_EN
  localparam logic [IDX_W:0] N_W = (IDX_W+1)'(N);
  logic [IDX_W:0] sum;
`endif

  always_comb begin
`ifdef WB_ARBITER_RR_EN
    // requester at ptr lands on bit 0 so the encoder starts its search there
    rot = N'({req, req} >> ptr);
`else
    rot = req;
`endif

    enc = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) enc = IDX_W'(k);
    end
    any = |rot;

`ifdef WB_ARBITER_RR_EN
    sum = {1'b0, enc} + {1'b0, ptr};
    if (sum >= N_W) sum = sum - N_W;
    idx = sum[IDX_W-1:0];
`else
    idx = enc;
`endif

    gnt = '0;
    for (int i = 0; i < N; i++) begin
      gnt[i] = any && (idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: grants one requester per cycle and registers its result onto
// the register-file write port one cycle later. Round-robin when WB_ARBITER_RR_EN is defined.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NREQ = 3
) (
  input logic         clk,
  input logic         rstn,
  wb_arbiter_if.slave bus
);

  logic [NREQ-1:0]  pick_req;
  logic [NREQ-1:0]  gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_any;

  wb_req_t          sel;
  wb_req_t          wr_d, wr_q;
  logic             wr_valid_d, wr_valid_q;
  logic [IDX_W-1:0] grant_id_d, grant_id_q;

`ifdef WB_ARBITER_RR_EN
  logic [IDX_W-1:0] ptr_d, ptr_q;
`endif

  // no grant while held in reset so nothing is consumed that cannot be written
  assign pick_req = (rstn && !bus.flush) ? bus.req_valid : '0;

  rr_picker #(.N(NREQ)) u_picker (
    .req (pick_req),
`ifdef WB_ARBITER_RR_EN
    .ptr (ptr_q),
`endif
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign bus.req_ready = gnt;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel.dest    = bus.req_dest[i];
        sel.data    = bus.req_data[i];
        sel.is_freg = bus.req_is_freg[i];
      end
    end

    wr_d       = sel;
    wr_valid_d = gnt_any;
    grant_id_d = gnt_any ? gnt_idx : '0;

`ifdef WB_ARBITER_RR_EN
    ptr_d = ptr_q;
    if (gnt_any) ptr_d = wrap_inc(gnt_idx, NREQ);
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q       <= '0;
      wr_valid_q <= 1'b0;
      grant_id_q <= '0;
`ifdef WB_ARBITER_RR_EN
      ptr_q      <= '0;
`endif
    end else begin
      wr_q       <= wr_d;
      wr_valid_q <= wr_valid_d;
      grant_id_q <= grant_id_d;
`ifdef WB_ARBITER_RR_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  // integer writes to x0 are consumed silently; f0 is a real register
  assign bus.reg_w_enable  = wr_valid_q & ~wr_q.is_freg & (wr_q.dest != 5'd0);
  assign bus.freg_w_enable = wr_valid_q & wr_q.is_freg;
  assign bus.reg_w_dest    = wr_q.dest;
  assign bus.reg_w_data    = wr_q.data;
  assign bus.grant_id      = grant_id_q;
  assign bus.busy          = (|bus.req_valid) | wr_valid_q;

endmodule
